// File: rtl/simd_pkg.sv
// Shared constants and helpers for the packed 16-bit SIMD add/sub datapath.
// Mode encodings, per-mode lane masks and the result bundle live here.
package simd_pkg;

    localparam int SIMD_W     = 16;
    localparam int SIMD_NIB_W = 4;
    localparam int SIMD_NIBS  = SIMD_W / SIMD_NIB_W;

    localparam logic [1:0] SIMD_M16 = 2'b00;
    localparam logic [1:0] SIMD_M8  = 2'b01;
    localparam logic [1:0] SIMD_M4  = 2'b10;

    typedef struct packed {
        logic [SIMD_W-1:0]    res;
        logic [SIMD_NIBS-1:0] flag;
    } simd_result_t;

    // The reserved encoding aliases the full-width mode.
    function automatic logic [1:0] simd_norm_mode(input logic [1:0] mode);
        return (mode == SIMD_M8 || mode == SIMD_M4) ? mode : SIMD_M16;
    endfunction

    function automatic logic [SIMD_NIBS-1:0] simd_lane_top_mask(input logic [1:0] mode);
        case (mode)
            SIMD_M8: return 4'b1010;
            SIMD_M4: return 4'b1111;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [SIMD_NIBS-1:0] simd_lane_low_mask(input logic [1:0] mode);
        case (mode)
            SIMD_M8: return 4'b0101;
            SIMD_M4: return 4'b1111;
            default: return 4'b0001;
        endcase
    endfunction

endpackage

// File: rtl/simd_lane_adder.sv
// Combinational nibble-sliced add/sub with lane-bounded carry chains.
// Build option: define SIMD_SAT_EN for per-lane unsigned saturation.
module simd_lane_adder
    import simd_pkg::*;
(
    input  logic [SIMD_W-1:0]    a,
    input  logic [SIMD_W-1:0]    b,
    input  logic [1:0]           mode,
    input  logic                 sub,
    output logic [SIMD_W-1:0]    result,
    output logic [SIMD_NIBS-1:0] carries
);

    logic [SIMD_W-1:0]    b_eff;
    logic [SIMD_W-1:0]    raw;
    logic [SIMD_NIBS-1:0] low_mask;
    logic                 carry_prev;
    logic                 cin;
    logic [SIMD_NIB_W:0]  nib_sum;

    assign b_eff    = sub ? ~b : b;
    assign low_mask = simd_lane_low_mask(mode);

    // Carry-in restarts at each lane's low nibble so lanes never interact.
    always_comb begin
        raw        = '0;
        carries    = '0;
        carry_prev = 1'b0;
        cin        = 1'b0;
        nib_sum    = '0;
        for (int i = 0; i < SIMD_NIBS; i++) begin
            cin        = low_mask[i] ? sub : carry_prev;
            nib_sum    = {1'b0, a[4*i +: 4]} + {1'b0, b_eff[4*i +: 4]} + {4'b0000, cin};
            raw[4*i +: 4] = nib_sum[3:0];
            carries[i] = nib_sum[4];
            carry_prev = nib_sum[4];
        end
    end

`ifdef SIMD_SAT_EN
    function automatic int lane_top_idx(input logic [1:0] m, input int nib);
        case (m)
            SIMD_M8: return nib | 1;
            SIMD_M4: return nib;
            default: return SIMD_NIBS - 1;
        endcase
    endfunction

    // Overflow clamps to all-ones on add, to zero on subtract.
    function automatic logic [3:0] sat_nibble(input logic [3:0] val, input logic ovf,
                                              input logic is_sub);
        if (!ovf)
            return val;
        return is_sub ? 4'h0 : 4'hF;
    endfunction

    always_comb begin
        result = raw;
        for (int i = 0; i < SIMD_NIBS; i++) begin
            result[4*i +: 4] = sat_nibble(raw[4*i +: 4],
                                          sub ^ carries[lane_top_idx(mode, i)], sub);
        end
    end
`else
    assign result = raw;
`endif

endmodule

// File: rtl/simd_addsub_issue.sv
// Handshaked issue stage for packed SIMD add/sub with an operand-A accumulator.
// Build option: SIMD_SAT_EN selects saturating lanes inside simd_lane_adder.
module simd_addsub_issue
    import simd_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SIMD_W-1:0]    in_a,
    input  logic [SIMD_W-1:0]    in_b,
    input  logic [1:0]           in_mode,
    input  logic                 in_sub,
    input  logic                 in_use_acc,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SIMD_W-1:0]    out_res,
    output logic [SIMD_NIBS-1:0] out_flag,
    output logic [SIMD_W-1:0]    acc
);

    logic [1:0]           mode_p0;
    logic [SIMD_W-1:0]    a_p0;
    logic [SIMD_W-1:0]    sum_p0;
    logic [SIMD_NIBS-1:0] carries_p0;
    simd_result_t         rslt_p0;
    logic                 accept_p0;

    simd_result_t         rslt_p1;
    logic                 vld_p1;
    logic [SIMD_W-1:0]    acc_p1;

    assign in_ready  = ~vld_p1 | out_ready;
    assign accept_p0 = in_valid & in_ready;
    assign mode_p0   = simd_norm_mode(in_mode);

    // A same-cycle clear takes effect before the accumulator is read.
    assign a_p0 = in_use_acc ? (acc_clr ? '0 : acc_p1) : in_a;

    simd_lane_adder u_lane_adder (
        .a       (a_p0),
        .b       (in_b),
        .mode    (mode_p0),
        .sub     (in_sub),
        .result  (sum_p0),
        .carries (carries_p0)
    );

    assign rslt_p0.res  = sum_p0;
    assign rslt_p0.flag = (carries_p0 ^ {SIMD_NIBS{in_sub}}) & simd_lane_top_mask(mode_p0);

    // ---- stage p0 -> p1: output register and accumulator ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            rslt_p1 <= '0;
            acc_p1  <= '0;
        end else if (accept_p0) begin
            vld_p1  <= 1'b1;
            rslt_p1 <= rslt_p0;
            acc_p1  <= rslt_p0.res;
        end else begin
            if (out_ready)
                vld_p1 <= 1'b0;
            if (acc_clr)
                acc_p1 <= '0;
        end
    end

    assign out_valid = vld_p1;
    assign out_res   = rslt_p1.res;
    assign out_flag  = rslt_p1.flag;
    assign acc       = acc_p1;

endmodule

// File: tb/tb_simd_addsub_issue.sv
// Directed self-checking bench for simd_addsub_issue (both SIMD_SAT_EN builds).
module tb_simd_addsub_issue;

`ifdef SIMD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [1:0]  in_mode;
    logic        in_sub;
    logic        in_use_acc;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_res;
    logic [3:0]  out_flag;
    logic [15:0] acc;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    simd_addsub_issue dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_mode    (in_mode),
        .in_sub     (in_sub),
        .in_use_acc (in_use_acc),
        .acc_clr    (acc_clr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_flag   (out_flag),
        .acc        (acc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic [1:0] mode,
                         input logic sub, input logic use_acc, input logic clr);
        in_valid   = 1'b1;
        in_a       = a;
        in_b       = b;
        in_mode    = mode;
        in_sub     = sub;
        in_use_acc = use_acc;
        acc_clr    = clr;
    endtask

    task automatic idle;
        in_valid   = 1'b0;
        in_use_acc = 1'b0;
        acc_clr    = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [1:0] mode, input logic sub,
                          input logic [15:0] exp_res, input logic [3:0] exp_flag);
        drive(a, b, mode, sub, 1'b0, 1'b0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        step;
        idle;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".res"},   32'(out_res),   32'(exp_res));
        check({tag, ".flag"},  32'(out_flag),  32'(exp_flag));
        check({tag, ".acc"},   32'(acc),       32'(exp_res));
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_mode   = 2'b00;
        in_sub    = 1'b0;
        idle;
        step;
        check("rst.in_ready", 32'(in_ready),  32'd1);
        check("rst.valid",    32'(out_valid), 32'd0);
        check("rst.res",      32'(out_res),   32'd0);
        check("rst.flag",     32'(out_flag),  32'd0);
        check("rst.acc",      32'(acc),       32'd0);
        step;
        rst       = 1'b0;
        out_ready = 1'b1;
        step;

        run_op("t1_4x4_add",  16'h1234, 16'h1111, 2'b10, 1'b0, 16'h2345, 4'b0000);
        run_op("t2_2x8_add",  16'h80FF, 16'h8001, 2'b01, 1'b0, SAT ? 16'hFFFF : 16'h0000, 4'b1010);
        run_op("t3_1x16_sub", 16'h0001, 16'h0002, 2'b00, 1'b1, SAT ? 16'h0000 : 16'hFFFF, 4'b1000);
        run_op("t4_4x4_subb", 16'h0000, 16'h1111, 2'b10, 1'b1, SAT ? 16'h0000 : 16'hFFFF, 4'b1111);
        run_op("t4_4x4_sub",  16'h5555, 16'h1111, 2'b10, 1'b1, 16'h4444, 4'b0000);
        run_op("t_rsv_mode",  16'hFFFF, 16'h0001, 2'b11, 1'b0, SAT ? 16'hFFFF : 16'h0000, 4'b1000);
        run_op("t_2x8_nocross", 16'h00FF, 16'h0001, 2'b01, 1'b0, SAT ? 16'h00FF : 16'h0000, 4'b0010);

        // Backpressure: first result must hold while the second op waits.
        step;
        out_ready = 1'b0;
        drive(16'h0001, 16'h0001, 2'b10, 1'b0, 1'b0, 1'b0);
        step;
        drive(16'h0010, 16'h0010, 2'b10, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp.valid",    32'(out_valid), 32'd1);
            check("bp.hold_res", 32'(out_res),   32'h0002);
            check("bp.in_ready", 32'(in_ready),  32'd0);
            step;
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'd1);
        step;
        idle;
        check("bp.second_valid", 32'(out_valid), 32'd1);
        check("bp.second_res",   32'(out_res),   32'h0020);
        check("bp.acc",          32'(acc),       32'h0020);
        step;
        check("bp.drained", 32'(out_valid), 32'd0);

        // Accumulator chain.
        acc_clr = 1'b1;
        step;
        idle;
        check("acc.clr_alone", 32'(acc), 32'h0000);
        drive(16'hDEAD, 16'h0101, 2'b01, 1'b0, 1'b1, 1'b0);
        step;
        check("acc.chain1", 32'(acc), 32'h0101);
        step;
        check("acc.chain2", 32'(acc), 32'h0202);
        step;
        check("acc.chain3",     32'(acc),     32'h0303);
        check("acc.chain3_res", 32'(out_res), 32'h0303);
        drive(16'hBEEF, 16'h0101, 2'b01, 1'b0, 1'b1, 1'b1);
        step;
        check("acc.clr_use_res", 32'(out_res), 32'h0101);
        check("acc.clr_use_acc", 32'(acc),     32'h0101);
        drive(16'h0010, 16'h0001, 2'b10, 1'b0, 1'b0, 1'b1);
        step;
        check("acc.clr_nouse", 32'(acc), 32'h0011);
        idle;
        acc_clr = 1'b1;
        step;
        idle;
        check("acc.clr_final", 32'(acc),       32'h0000);
        check("acc.idle_valid", 32'(out_valid), 32'd0);

        // Reset with a held result drops it.
        out_ready = 1'b0;
        drive(16'h0003, 16'h0004, 2'b10, 1'b0, 1'b0, 1'b0);
        step;
        idle;
        check("rst2.pre_valid", 32'(out_valid), 32'd1);
        check("rst2.pre_acc",   32'(acc),       32'h0007);
        rst = 1'b1;
        step;
        check("rst2.valid",    32'(out_valid), 32'd0);
        check("rst2.acc",      32'(acc),       32'h0000);
        check("rst2.res",      32'(out_res),   32'h0000);
        check("rst2.in_ready", 32'(in_ready),  32'd1);
        rst = 1'b0;
        step;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
